input_ram_arb: RTL and testbench
================================

INPUT_RAM_ARB -- requirements
Module: input_ram_arb

Interface
REQ-001 Parameter: BURST_MAX, default 8, maximum consecutive grants to one requester while the other waits (legal range 1..15).
REQ-002 Port: clk  input  1  system clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous and active-high.
REQ-004 Port: a_req  input  1  loader requester (UART side) access request.
REQ-005 Port: a_we  input  1  loader write enable; 0 means read.
REQ-006 Port: a_addr  input  10  loader bit address.
REQ-007 Port: a_wdata  input  1  loader write bit.
REQ-008 Port: a_gnt  output  1  loader granted this cycle.
REQ-009 Port: a_rvalid  output  1  loader read data valid.
REQ-010 Port: b_req  input  1  core requester read request (read-only).
REQ-011 Port: b_addr  input  10  core bit address.
REQ-012 Port: b_gnt  output  1  core granted this cycle.
REQ-013 Port: b_rvalid  output  1  core read data valid.
REQ-014 Port: rdata  output  1  shared read data, equal to ram_q.
REQ-015 Port: ram_addr / ram_we / ram_d  output  10/1/1  single-port input RAM controls.
REQ-016 Port: ram_q  input  1  RAM read data, valid one cycle after address.
REQ-017 Port: err  output  1  sticky out-of-range flag; err_clr  input  1  clears it.

Function
REQ-018 States: IDLE, OWN_A, OWN_B (registered); grants are combinational from state, requests, rr pointer and burst count.
REQ-019 IDLE: sole requester granted; both requesting -> grant the side not served last (rr pointer).
REQ-020 OWN_X: grant X if x_req and (other not requesting or burst_cnt < BURST_MAX-1); else grant other if requesting; else no grant.
REQ-021 Next state = granted side's OWN state; IDLE when no grant.
REQ-022 burst_cnt (4 bit) clears on owner change or IDLE, increments on each consecutive grant to the same owner, saturates at BURST_MAX-1.
REQ-023 rr pointer updates to the granted side every granted cycle.
REQ-024 At most one of a_gnt/b_gnt is high in any cycle.
REQ-025 ram_addr = granted requester's address; holds last value when no grant.
REQ-026 ram_we = a_gnt & a_we & (a_addr < 784); ram_d = a_wdata.
REQ-027 x_rvalid pulses high exactly one cycle after a granted read (loader a_we=0 or any core grant); rdata is valid that cycle.
REQ-028 Granted access with address >= 784 (0x310): write suppressed, read still returns rvalid with rdata forced 0, err set the next cycle.
REQ-029 err_clr and a new error in the same cycle: err remains 1 (set wins).
REQ-030 Ungranted requester retains its request; no request is dropped or queued internally.

Reset
REQ-031 On rst: state IDLE, burst_cnt 0, rr pointer = A-served (tie goes to B first), a_gnt/b_gnt/rvalid 0, ram_we 0, ram_addr 0, err 0.
REQ-032 rst asserted mid-burst aborts it; a pending rvalid is discarded; no RAM write occurs while rst is high.

Configuration
REQ-033 Macro INPUT_RAM_ARB_STATS_EN: when defined, adds output conflict_cnt (16 bit) counting cycles with both requests high and one denied, saturating at 0xFFFF, reset to 0, cleared by err_clr; when undefined the port and counter do not exist and behaviour is otherwise identical.

Verification
REQ-034 Reset, then a_req=1, a_we=1, a_addr=5, a_wdata=1 alone -> a_gnt=1 same cycle, ram_we=1, ram_addr=5; b_gnt=0.
REQ-035 Both request from IDLE after reset -> b_gnt first; next cycle with both still requesting, B keeps grant for 8 cycles total, then A is granted for cycle 9.
REQ-036 b_req read of addr 0x10 with ram_q=1 -> b_rvalid=1 and rdata=1 exactly one cycle later; a_rvalid stays 0.
REQ-037 Loader write to addr 0x310 -> ram_we=0, err=1 next cycle; err_clr pulse -> err=0; simultaneous err_clr and new error -> err=1.
REQ-038 rst asserted during OWN_A burst at burst_cnt=3 -> all outputs 0 immediately, state IDLE after release, next tie grants B.
REQ-039 With INPUT_RAM_ARB_STATS_EN, 10 cycles of both requests -> conflict_cnt=10.

Source files
------------

// File: rtl/input_ram_arb.sv
// Two-requester arbiter for the single-port input bit RAM: loader (A) and core (B).
// Optional conflict counter enabled by defining INPUT_RAM_ARB_STATS_EN.
module input_ram_arb #(
  parameter int unsigned BURST_MAX = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       a_req,
  input  logic       a_we,
  input  logic [9:0] a_addr,
  input  logic       a_wdata,
  output logic       a_gnt,
  output logic       a_rvalid,
  input  logic       b_req,
  input  logic [9:0] b_addr,
  output logic       b_gnt,
  output logic       b_rvalid,
  output logic       rdata,
  output logic [9:0] ram_addr,
  output logic       ram_we,
  output logic       ram_d,
  input  logic       ram_q,
  output logic       err,
  input  logic       err_clr
`ifdef INPUT_RAM_ARB_STATS_EN
  ,
  output logic [15:0] conflict_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;

  localparam logic [3:0] BURST_LAST = 4'(BURST_MAX - 1);
  localparam logic [9:0] ADDR_LIMIT = 10'd784;

  state_t     state, next_state;
  logic [3:0] burst_cnt, burst_next;
  logic       rr_b;        // 1: B was served last
  logic [9:0] addr_q, sel_addr;
  logic       a_rv_q, b_rv_q, oor_q, oor;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      burst_cnt <= '0;
      rr_b      <= 1'b0;
      addr_q    <= '0;
      a_rv_q    <= 1'b0;
      b_rv_q    <= 1'b0;
      oor_q     <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= next_state;
      burst_cnt <= burst_next;
      if (b_gnt)      rr_b <= 1'b1;
      else if (a_gnt) rr_b <= 1'b0;
      addr_q    <= sel_addr;
      a_rv_q    <= a_gnt & ~a_we;
      b_rv_q    <= b_gnt;
      oor_q     <= oor;
      if (oor)          err <= 1'b1;
      else if (err_clr) err <= 1'b0;
    end
  end

  // Grants are held low during reset so nothing reaches the RAM while rst is high.
  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (a_req && b_req) begin
            a_gnt = rr_b;
            b_gnt = ~rr_b;
          end else begin
            a_gnt = a_req;
            b_gnt = b_req;
          end
        end
        OWN_A: begin
          if (a_req && (!b_req || burst_cnt < BURST_LAST)) a_gnt = 1'b1;
          else if (b_req)                                 b_gnt = 1'b1;
        end
        OWN_B: begin
          if (b_req && (!a_req || burst_cnt < BURST_LAST)) b_gnt = 1'b1;
          else if (a_req)                                 a_gnt = 1'b1;
        end
        default: ;
      endcase
    end

    next_state = IDLE;
    if (a_gnt)      next_state = OWN_A;
    else if (b_gnt) next_state = OWN_B;

    burst_next = '0;
    if ((state == OWN_A && a_gnt) || (state == OWN_B && b_gnt))
      burst_next = (burst_cnt == BURST_LAST) ? burst_cnt : burst_cnt + 4'd1;
  end

  always_comb begin
    sel_addr = addr_q;
    if (a_gnt)      sel_addr = a_addr;
    else if (b_gnt) sel_addr = b_addr;
    oor = (a_gnt | b_gnt) && (sel_addr >= ADDR_LIMIT);
  end

  assign ram_addr = sel_addr;
  assign ram_we   = a_gnt & a_we & (a_addr < ADDR_LIMIT);
  assign ram_d    = a_wdata;
  assign a_rvalid = a_rv_q;
  assign b_rvalid = b_rv_q;
  assign rdata    = ram_q & ~oor_q;

`ifdef INPUT_RAM_ARB_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      conflict_cnt <= '0;
    else if (err_clr)
      conflict_cnt <= '0;
    else if (a_req && b_req && (a_gnt || b_gnt) && conflict_cnt != '1)
      conflict_cnt <= conflict_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_input_ram_arb.sv
// Randomized and directed checks of input_ram_arb against a streak-based reference model.
module tb_input_ram_arb;
  localparam int unsigned BM = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic a_req = 1'b0, a_we = 1'b0, a_wdata = 1'b0, b_req = 1'b0, err_clr = 1'b0;
  logic [9:0] a_addr = '0, b_addr = '0;
  logic a_gnt, a_rvalid, b_gnt, b_rvalid, rdata, ram_we, ram_d, ram_q, err;
  logic [9:0] ram_addr;
`ifdef INPUT_RAM_ARB_STATS_EN
  logic [15:0] conflict_cnt;
`endif

  input_ram_arb #(.BURST_MAX(BM)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid),
    .b_req(b_req), .b_addr(b_addr), .b_gnt(b_gnt), .b_rvalid(b_rvalid),
    .rdata(rdata), .ram_addr(ram_addr), .ram_we(ram_we), .ram_d(ram_d),
    .ram_q(ram_q), .err(err), .err_clr(err_clr)
`ifdef INPUT_RAM_ARB_STATS_EN
    , .conflict_cnt(conflict_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic bit init_bit(input int i);
    return ((i % 3) != 2) || (i >= 784);
  endfunction

  logic mem [1024];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 1024; i++) mem[i] <= init_bit(i);
    end else if (ram_we) begin
      mem[ram_addr] <= ram_d;
    end
    ram_q <= mem[ram_addr];
  end

  // Reference model: who was granted last, for how many consecutive cycles, who was served last.
  int m_last, m_served, m_streak, m_conf;
  logic [9:0] m_addr;
  bit m_rva, m_rvb, m_rd, m_err;
  bit ref_mem [1024];
  bit e_ga, e_gb, e_we;
  logic [9:0] e_addr;
  int tests = 0, fails = 0;

  task automatic model_reset();
    m_last = 0; m_served = 1; m_streak = 0; m_conf = 0; m_addr = '0;
    m_rva = 0; m_rvb = 0; m_rd = 0; m_err = 0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_bit(i);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    a_req = 0; b_req = 0; err_clr = 0;
    #1 model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drive(input bit ar, input bit aw, input logic [9:0] aa, input bit ad,
                       input bit br, input logic [9:0] ba, input bit ec);
    a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
    b_req = br; b_addr = ba; err_clr = ec;
    e_ga = 0; e_gb = 0;
    if (ar && !br) e_ga = 1;
    else if (br && !ar) e_gb = 1;
    else if (ar && br) begin
      if (m_last != 0 && m_streak < int'(BM)) begin
        e_ga = (m_last == 1); e_gb = (m_last == 2);
      end else begin
        e_ga = (m_served == 2); e_gb = (m_served == 1);
      end
    end
    e_addr = e_ga ? aa : (e_gb ? ba : m_addr);
    e_we = e_ga && aw && (aa < 10'd784);
    #1;
  endtask

  task automatic tick();
    int g;
    bit oor;
    @(posedge clk);
    g = e_ga ? 1 : (e_gb ? 2 : 0);
    oor = (g != 0) && (e_addr >= 10'd784);
    m_rva = e_ga && !a_we;
    m_rvb = e_gb;
    m_rd = oor ? 1'b0 : ref_mem[e_addr];
    if (e_we) ref_mem[e_addr] = a_wdata;
    if (oor) m_err = 1; else if (err_clr) m_err = 0;
    if (err_clr) m_conf = 0;
    else if (a_req && b_req && g != 0 && m_conf < 65535) m_conf++;
    m_streak = (g != 0 && g == m_last) ? m_streak + 1 : ((g != 0) ? 1 : 0);
    m_last = g;
    if (g != 0) m_served = g;
    m_addr = e_addr;
    @(negedge clk);
  endtask

  task automatic test_reset();
    tests++;
    if ({a_gnt, b_gnt, a_rvalid, b_rvalid, ram_we, err} !== 6'b0 || ram_addr !== 10'd0) begin
      fails++;
      $display("FAIL reset_state: gnt=%b%b rv=%b%b we=%b err=%b addr=%0d, required all 0",
               a_gnt, b_gnt, a_rvalid, b_rvalid, ram_we, err, ram_addr);
    end
    rst = 1'b0;
  endtask

  task automatic test_single_write();
    drive(1, 1, 10'd5, 1, 0, 10'd0, 0);
    tests++;
    if (a_gnt !== 1'b1 || b_gnt !== 1'b0 || ram_we !== 1'b1 || ram_addr !== 10'd5) begin
      fails++;
      $display("FAIL single_write: a_gnt=%b b_gnt=%b ram_we=%b ram_addr=%0d, required 1 0 1 5",
               a_gnt, b_gnt, ram_we, ram_addr);
    end
    tick();
    drive(0, 0, 10'd0, 0, 0, 10'd0, 0);
    tests++;
    if (a_rvalid !== 1'b0 || ram_addr !== 10'd5) begin
      fails++;
      $display("FAIL write_no_rvalid: a_rvalid=%b ram_addr=%0d, required 0 5", a_rvalid, ram_addr);
    end
    tick();
  endtask

  task automatic test_burst();
    apply_reset();
    for (int c = 1; c <= 9; c++) begin
      drive(1, 0, 10'(c), 0, 1, 10'(100 + c), 0);
      tests++;
      if ({a_gnt, b_gnt} !== ((c <= 8) ? 2'b01 : 2'b10)) begin
        fails++;
        $display("FAIL burst_cycle%0d: a_gnt,b_gnt=%b, required %b", c, {a_gnt, b_gnt},
                 (c <= 8) ? 2'b01 : 2'b10);
      end
      tick();
    end
  endtask

  task automatic test_core_read();
    apply_reset();
    drive(0, 0, 10'd0, 0, 1, 10'h10, 0);
    tick();
    drive(0, 0, 10'd0, 0, 0, 10'd0, 0);
    tests++;
    if (b_rvalid !== 1'b1 || rdata !== 1'b1 || a_rvalid !== 1'b0) begin
      fails++;
      $display("FAIL core_read: b_rvalid=%b rdata=%b a_rvalid=%b, required 1 1 0",
               b_rvalid, rdata, a_rvalid);
    end
    tick();
    tests++;
    if (b_rvalid !== 1'b0) begin
      fails++;
      $display("FAIL core_read_pulse: b_rvalid=%b, required 0", b_rvalid);
    end
  endtask

  task automatic test_err();
    apply_reset();
    drive(1, 1, 10'h310, 1, 0, 10'd0, 0);
    tests++;
    if (ram_we !== 1'b0 || a_gnt !== 1'b1 || err !== 1'b0) begin
      fails++;
      $display("FAIL oor_write: ram_we=%b a_gnt=%b err=%b, required 0 1 0", ram_we, a_gnt, err);
    end
    tick();
    drive(0, 0, 10'd0, 0, 0, 10'd0, 1);
    tests++;
    if (err !== 1'b1) begin
      fails++;
      $display("FAIL err_set: err=%b, required 1", err);
    end
    tick();
    drive(1, 1, 10'h310, 0, 0, 10'd0, 1);
    tests++;
    if (err !== 1'b0) begin
      fails++;
      $display("FAIL err_clear: err=%b, required 0", err);
    end
    tick();
    drive(1, 0, 10'h3FF, 0, 0, 10'd0, 0);
    tests++;
    if (err !== 1'b1) begin
      fails++;
      $display("FAIL err_set_wins: err=%b, required 1", err);
    end
    tick();
    drive(0, 0, 10'd0, 0, 0, 10'd0, 0);
    tests++;
    if (a_rvalid !== 1'b1 || rdata !== 1'b0) begin
      fails++;
      $display("FAIL oor_read: a_rvalid=%b rdata=%b, required 1 0", a_rvalid, rdata);
    end
    tick();
  endtask

  task automatic test_reset_mid_burst();
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1, (i < 3), 10'(20 + i), 1, 0, 10'd0, 0);
      tick();
    end
    a_req = 1; b_req = 1; a_we = 1; a_addr = 10'd30; rst = 1'b1;
    #1;
    tests++;
    if ({a_gnt, b_gnt, a_rvalid, b_rvalid, ram_we, err} !== 6'b0 || ram_addr !== 10'd0) begin
      fails++;
      $display("FAIL reset_mid_burst: gnt=%b%b rv=%b%b we=%b err=%b addr=%0d, required all 0",
               a_gnt, b_gnt, a_rvalid, b_rvalid, ram_we, err, ram_addr);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    drive(1, 0, 10'd7, 0, 1, 10'd9, 0);
    tests++;
    if (a_gnt !== 1'b0 || b_gnt !== 1'b1 || ram_addr !== 10'd9) begin
      fails++;
      $display("FAIL tie_after_reset: a_gnt=%b b_gnt=%b ram_addr=%0d, required 0 1 9",
               a_gnt, b_gnt, ram_addr);
    end
    tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 500; n++) begin
      bit ar, br;
      logic [9:0] aa, ba;
      ar = ($urandom_range(0, 3) != 0);
      br = ($urandom_range(0, 3) != 0);
      aa = ($urandom_range(0, 7) == 0) ? 10'(780 + $urandom_range(0, 8)) : 10'($urandom_range(0, 1023));
      ba = ($urandom_range(0, 7) == 0) ? 10'(780 + $urandom_range(0, 8)) : 10'($urandom_range(0, 1023));
      drive(ar, 1'($urandom), aa, 1'($urandom), br, ba, ($urandom_range(0, 15) == 0));
      tests++;
      if (a_gnt !== e_ga || b_gnt !== e_gb || ram_we !== e_we || ram_addr !== e_addr) begin
        fails++;
        $display("FAIL rand_grant n=%0d: gnt=%b%b we=%b addr=%0d, required %b%b %b %0d",
                 n, a_gnt, b_gnt, ram_we, ram_addr, e_ga, e_gb, e_we, e_addr);
      end
      tests++;
      if (a_rvalid !== m_rva || b_rvalid !== m_rvb || err !== m_err ||
          ((m_rva || m_rvb) && rdata !== m_rd)) begin
        fails++;
        $display("FAIL rand_read n=%0d: rv=%b%b rdata=%b err=%b, required %b%b %b %b",
                 n, a_rvalid, b_rvalid, rdata, err, m_rva, m_rvb, m_rd, m_err);
      end
`ifdef INPUT_RAM_ARB_STATS_EN
      tests++;
      if (conflict_cnt !== 16'(m_conf)) begin
        fails++;
        $display("FAIL rand_conflict n=%0d: conflict_cnt=%0d, required %0d", n, conflict_cnt, m_conf);
      end
`endif
      tick();
    end
  endtask

`ifdef INPUT_RAM_ARB_STATS_EN
  task automatic test_stats();
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      drive(1, 0, 10'(i), 0, 1, 10'(i + 50), 0);
      tick();
    end
    drive(0, 0, 10'd0, 0, 0, 10'd0, 0);
    tests++;
    if (conflict_cnt !== 16'd10) begin
      fails++;
      $display("FAIL conflict_cnt: got %0d, required 10", conflict_cnt);
    end
    drive(0, 0, 10'd0, 0, 0, 10'd0, 1);
    tick();
    drive(0, 0, 10'd0, 0, 0, 10'd0, 0);
    tests++;
    if (conflict_cnt !== 16'd0) begin
      fails++;
      $display("FAIL conflict_clr: got %0d, required 0", conflict_cnt);
    end
  endtask
`endif

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    test_reset();
    test_single_write();
    test_burst();
    test_core_read();
    test_err();
    test_reset_mid_burst();
    test_random();
`ifdef INPUT_RAM_ARB_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
